// File: rtl/sw_reader.sv
// sw_reader: slide-switch read port for the core.
// Raw switch levels are synchronized, debounced, and every settled value is
// captured into a holding register. The core sees the value plus a
// valid/overflow status word; a read strobe clears the status on the next edge.
module sw_reader #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] SW_i,
    input  logic             rd_en_i,
    output logic [31:0]      rdata_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             changed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic             valid_q;
    logic             ovf_q;
    logic             changed_q;

    logic [WIDTH-1:0] cand_d;
    logic [CNT_W-1:0] cnt_d;
    logic [0:0]       state_d;
    logic             commit;

    // Two-flop synchronizer; only sync2 is safe to use downstream.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking here so sync2 takes the old sync1, giving two real stages.
            sync1 <= SW_i;
            sync2 <= sync1;
        end
    end

    // Debounce FSM next-state: a candidate must stay unchanged for
    // DEBOUNCE_CYCLES counted cycles before it replaces the stable value.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        commit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync2 != stable) begin
                    cand_d  = sync2;
                    cnt_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync2 == stable) begin
                    // Input bounced back to the accepted value: abandon.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sync2 != cand) begin
                    // A different value appeared: restart qualification on it.
                    cand_d = sync2;
                    cnt_d  = '0;
                end else if (cnt == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Debounce FSM registers and the accepted (stable) value.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            state <= state_d;
            cand  <= cand_d;
            cnt   <= cnt_d;
            if (commit) begin
                stable <= cand;
            end
        end
    end

    // Status flags: a commit sets valid (beating a same-cycle read), a commit
    // onto an unread value flags overflow, and any read clears overflow.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= commit;

            if (commit) begin
                valid_q <= 1'b1;
            end else if (rd_en_i) begin
                valid_q <= 1'b0;
            end

            if (commit && valid_q && !rd_en_i) begin
                ovf_q <= 1'b1;
            end else if (rd_en_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Read word is a pure decode of registers; it never looks at rd_en_i.
    always_comb begin
        rdata_o              = '0;
        rdata_o[WIDTH-1:0]   = stable;
        rdata_o[30]          = ovf_q;
        rdata_o[31]          = valid_q;
    end

    assign valid_o   = valid_q;
    assign ovf_o     = ovf_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_sw_reader.sv
// tb_sw_reader: directed scenarios plus randomized switch activity, checked
// every cycle against a behavioural model of the switch reader.
module tb_sw_reader;

    localparam int W = 10;
    localparam int D = 4;

    logic          clk_i;
    logic          reset_n;
    logic [W-1:0]  SW_i;
    logic          rd_en_i;
    logic [31:0]   rdata_o;
    logic          valid_o;
    logic          ovf_o;
    logic          changed_o;

    int n_cmp;
    int n_bad;

    // Model state: two-stage delay of the sampled switches, length of the
    // current run of identical synchronized values, and the status flags.
    logic [W-1:0] m_p1, m_p2, m_prev, m_stable;
    int           m_run;
    logic         m_valid, m_ovf, m_changed;

    sw_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .SW_i      (SW_i),
        .rd_en_i   (rd_en_i),
        .rdata_o   (rdata_o),
        .valid_o   (valid_o),
        .ovf_o     (ovf_o),
        .changed_o (changed_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_prev = '0; m_stable = '0;
        m_run = 1;
        m_valid = 1'b0; m_ovf = 1'b0; m_changed = 1'b0;
    endtask

    // One clock edge of the model. A value is accepted once the synchronized
    // input has shown it D+1 edges in a row and it differs from the accepted one.
    task automatic model_edge(input logic [W-1:0] sw, input logic rd);
        logic commit;
        logic [W-1:0] s2;
        s2 = m_p2;
        if (s2 == m_prev) m_run = m_run + 1;
        else              m_run = 1;
        m_prev = s2;
        commit = (m_run == D + 1) && (s2 != m_stable);
        if (commit && m_valid && !rd) m_ovf = 1'b1;
        else if (rd)                  m_ovf = 1'b0;
        if (commit)   m_valid = 1'b1;
        else if (rd)  m_valid = 1'b0;
        if (commit) m_stable = s2;
        m_changed = commit;
        m_p2 = m_p1;
        m_p1 = sw;
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        w[W-1:0] = m_stable;
        w[30] = m_ovf;
        w[31] = m_valid;
        return w;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rdata"},   rdata_o,          model_word());
        check({tag, ".valid"},   32'(valid_o),     32'(m_valid));
        check({tag, ".ovf"},     32'(ovf_o),       32'(m_ovf));
        check({tag, ".changed"}, 32'(changed_o),   32'(m_changed));
    endtask

    // Apply inputs mid-cycle, take one edge, then compare just after it.
    task automatic tick(input logic [W-1:0] sw, input logic rd);
        SW_i    = sw;
        rd_en_i = rd;
        @(posedge clk_i);
        if (reset_n) model_edge(sw, rd);
        #1;
        check_all("cyc");
    endtask

    // Hold a value for n edges with no reads; returns commits seen and the
    // edge index (1-based) of the first one, 0 if none.
    task automatic hold(input logic [W-1:0] sw, input int n, output int commits, output int first);
        commits = 0;
        first   = 0;
        for (int i = 1; i <= n; i++) begin
            tick(sw, 1'b0);
            if (changed_o) begin
                commits++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int c, f, total;
        logic [W-1:0] v;
        n_cmp = 0;
        n_bad = 0;
        model_reset();

        // Reset held with non-zero switches: everything reads zero.
        reset_n = 1'b0;
        SW_i    = 10'b0000110010;
        rd_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(10'h032, 1'b0);
            check("rst_rdata", rdata_o, 32'h0);
        end
        reset_n = 1'b1;

        // Release: value commits on edge D+3 with a single changed pulse.
        hold(10'h032, D + 5, c, f);
        check("rel_first", 32'(f), 32'(D + 3));
        check("rel_count", 32'(c), 32'd1);
        check("rel_rdata", rdata_o, 32'h8000_0032);

        // Clean change, then read clears the status.
        hold(10'h3FF, D + 3, c, f);
        check("chg_first", 32'(f), 32'(D + 3));
        check("chg_data", {22'h0, rdata_o[9:0]}, 32'h3FF);
        tick(10'h3FF, 1'b1);
        check("chg_read", rdata_o, 32'h0000_03FF);

        // Bounce on bit 0 from a stable 0x3FE, then settle at 0x3FF.
        hold(10'h3FE, D + 4, c, f);
        tick(10'h3FE, 1'b1);
        total = 0;
        for (int i = 0; i < 10; i++) begin
            hold((i % 2 == 0) ? 10'h3FF : 10'h3FE, 2, c, f);
            total += c;
        end
        check("bnc_none", 32'(total), 32'd0);
        hold(10'h3FF, D + 6, c, f);
        check("bnc_first", 32'(f), 32'(D + 3));
        check("bnc_count", 32'(c), 32'd1);
        tick(10'h3FF, 1'b1);

        // Bounce back: short pulse away from stable 0 never commits.
        hold(10'h000, D + 4, c, f);
        tick(10'h000, 1'b1);
        hold(10'h001, 3, c, f);
        total = c;
        hold(10'h000, D + 5, c, f);
        total += c;
        check("bb_none", 32'(total), 32'd0);
        check("bb_valid", 32'(valid_o), 32'd0);

        // Overflow: two commits without a read in between.
        hold(10'h005, D + 4, c, f);
        hold(10'h00A, D + 4, c, f);
        check("ovf_word", rdata_o, 32'hC000_000A);
        tick(10'h00A, 1'b1);
        check("ovf_rd_valid", 32'(valid_o), 32'd0);
        check("ovf_rd_ovf", 32'(ovf_o), 32'd0);

        // Read on the commit edge while valid: new value held, valid stays, no ovf.
        hold(10'h0F0, D + 4, c, f);
        hold(10'h00F, D + 2, c, f);
        tick(10'h00F, 1'b1);
        check("sim_changed", 32'(changed_o), 32'd1);
        check("sim_word", rdata_o, 32'h8000_000F);

        // Reset during COUNT: outputs drop at once, candidate is lost.
        hold(10'h2AA, 4, c, f);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_rdata", rdata_o, 32'h0);
        check("mid_rst_changed", 32'(changed_o), 32'd0);
        tick(10'h2AA, 1'b0);
        tick(10'h2AA, 1'b0);
        reset_n = 1'b1;
        hold(10'h2AA, D + 5, c, f);
        check("mid_rst_first", 32'(f), 32'(D + 3));
        check("mid_rst_word", rdata_o, 32'h8000_02AA);

        // Randomized activity: hold segments of random length, occasional
        // single-bit flips, random read strobes.
        v = 10'h2AA;
        for (int s = 0; s < 60; s++) begin
            int len;
            if ($urandom_range(0, 1) == 0) v = W'($urandom);
            else                           v = v ^ (W'(1) << $urandom_range(0, W - 1));
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                tick(v, ($urandom_range(0, 3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
